ahb_slave_mux: RTL and testbench

- Parametrised AHB-Lite slave-side response multiplexer and default slave for the uncore. It replaces the fixed-width hand-written read/ready/resp mux and select-delay register.
- Takes one-hot region selects from the address decoder and registers the data-phase select. It returns HRDATA/HREADY/HRESP from N slaves.
- It generates a proper two-cycle AHB ERROR for unmapped or illegal accesses.
- A per-transfer stall watchdog abandons hung slaves with an ERROR response and fences them off until they recover.

---
 rtl/ahb_pkg.sv | 18 +
 rtl/ahb_stall_watchdog.sv | 31 +++
 rtl/ahb_slave_mux.sv | 159 +++++++++++++++
 tb/tb_ahb_slave_mux.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the uncore slave-side mux.
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    // Response mux state: normal data phase, or first/second cycle of an ERROR
    typedef enum logic [1:0] {DATA, ERR1, ERR2} ahbmux_state_t;

    // True when more than one bit is set (decoder produced an overlapping select)
    function automatic logic multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/ahb_stall_watchdog.sv
// Counts consecutive data-phase stall cycles and flags when the limit is hit.
module ahb_stall_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic HCLK,
    input  logic reset,
    input  logic Stall,
    input  logic Clear,
    output logic Expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Stall counter: cleared on completion/no select, saturates instead of wrapping
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (Clear) begin
            r_count <= '0;
        end else if (Stall && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Only fires while still stalled, so a slave readying on the last cycle wins
    assign Expire = Stall && (r_count == LIMIT);

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave response mux with built-in default slave and stall watchdog.
module ahb_slave_mux
    import ahb_pkg::*;
#(
    parameter int unsigned NSLV    = 8,
    parameter int unsigned DW      = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                HCLK,
    input  logic                reset,
    input  logic [1:0]          HTRANS,
    input  logic [NSLV-1:0]     HSEL,
    output logic [NSLV-1:0]     HSELOut,
    input  logic [NSLV*DW-1:0]  HRDATAS,
    input  logic [NSLV-1:0]     HREADYOUTS,
    input  logic [NSLV-1:0]     HRESPS,
    output logic [DW-1:0]       HRDATA,
    output logic                HREADY,
    output logic                HRESP,
    output logic [NSLV-1:0]     Orphan,
    output logic                TimeoutPulse
);

    logic [NSLV-1:0] r_sel_d;
    logic            r_none_err_d;
    logic [NSLV-1:0] r_orphan;
    logic [NSLV-1:0] w_orphan_nxt;
    ahbmux_state_t   r_state;
    ahbmux_state_t   w_state_nxt;

    logic [31:0]     w_hsel_ext;
    logic            w_illegal;
    logic [DW-1:0]   w_slv_rdata;
    logic            w_slv_ready;
    logic            w_slv_resp;
    logic            w_stall;
    logic            w_clear;
    logic            w_expire;

    // Orphaned slaves never see a select until they finally respond
    assign HSELOut = HSEL & ~r_orphan;
    assign Orphan  = r_orphan;

    // Widen the select for the overlap check
    always_comb begin
        w_hsel_ext           = '0;
        w_hsel_ext[NSLV-1:0] = HSEL;
    end

    assign w_illegal = multi_hot(w_hsel_ext);

    // AND-OR read-data mux; r_sel_d is one-hot or zero by construction
    always_comb begin
        w_slv_rdata = '0;
        for (int i = 0; i < int'(NSLV); i++) begin
            if (r_sel_d[i]) begin
                w_slv_rdata = w_slv_rdata | HRDATAS[i*DW +: DW];
            end
        end
    end

    assign w_slv_ready = |(r_sel_d & HREADYOUTS);
    assign w_slv_resp  = |(r_sel_d & HRESPS);

    // Capture the data-phase select whenever the bus advances
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            r_sel_d      <= '0;
            r_none_err_d <= 1'b0;
        end else if (HREADY) begin
            r_sel_d      <= w_illegal ? '0 : HSELOut;
            r_none_err_d <= HTRANS[1] & ((HSELOut == '0) | w_illegal);
        end
    end

    assign w_stall = (r_state == DATA) && (r_sel_d != '0) && !w_slv_ready;
    assign w_clear = HREADY || (r_sel_d == '0);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            ahb_stall_watchdog #(
                .TIMEOUT (TIMEOUT)
            ) u_wdog (
                .HCLK   (HCLK),
                .reset  (reset),
                .Stall  (w_stall),
                .Clear  (w_clear),
                .Expire (w_expire)
            );
        end else begin : g_no_wdog
            assign w_expire = 1'b0;
        end
    endgenerate

    // Response state register
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            r_state <= DATA;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and bus response outputs
    always_comb begin
        w_state_nxt  = r_state;
        HREADY       = 1'b1;
        HRESP        = 1'b0;
        HRDATA       = '0;
        TimeoutPulse = 1'b0;
        unique case (r_state)
            DATA: begin
                if (r_none_err_d) begin
                    HREADY      = 1'b0;
                    HRESP       = 1'b1;
                    w_state_nxt = ERR2;
                end else if (r_sel_d != '0) begin
                    HRDATA = w_slv_rdata;
                    HREADY = w_slv_ready;
                    HRESP  = w_slv_resp;
                    if (w_expire) begin
                        TimeoutPulse = 1'b1;
                        w_state_nxt  = ERR1;
                    end
                end
            end
            ERR1: begin
                HREADY      = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = ERR2;
            end
            ERR2: begin
                HRESP       = 1'b1;
                w_state_nxt = DATA;
            end
            default: begin
                w_state_nxt = DATA;
            end
        endcase
    end

    // Late response from an orphan releases it; an abort fences the stalled slave
    always_comb begin
        w_orphan_nxt = r_orphan & ~HREADYOUTS;
        if (r_state == DATA && w_expire) begin
            w_orphan_nxt = w_orphan_nxt | r_sel_d;
        end
    end

    // Sticky orphan flags
    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            r_orphan <= '0;
        end else begin
            r_orphan <= w_orphan_nxt;
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed testbench for ahb_slave_mux (NSLV=8, DW=64, TIMEOUT=16).
module tb_ahb_slave_mux;
    import ahb_pkg::*;

    localparam int NSLV    = 8;
    localparam int DW      = 64;
    localparam int TIMEOUT = 16;

    localparam int K_OK   = 0;
    localparam int K_ERR  = 1;
    localparam int K_IDLE = 2;
    localparam int K_SERR = 3;

    logic                HCLK = 1'b0;
    logic                reset;
    logic [1:0]          HTRANS;
    logic [NSLV-1:0]     HSEL;
    logic [NSLV-1:0]     HSELOut;
    logic [NSLV*DW-1:0]  HRDATAS;
    logic [NSLV-1:0]     HREADYOUTS;
    logic [NSLV-1:0]     HRESPS;
    logic [DW-1:0]       HRDATA;
    logic                HREADY;
    logic                HRESP;
    logic [NSLV-1:0]     Orphan;
    logic                TimeoutPulse;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NSLV-1:0] idle_rdy;

    typedef struct {
        string       name;
        logic [1:0]  htrans;
        logic [7:0]  hsel;
        logic [7:0]  hselout;
        int          slv;
        int          waits;
        logic [63:0] data;
        int          kind;
    } vec_t;

    vec_t vecs [10];

    ahb_slave_mux #(
        .NSLV    (NSLV),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .HCLK         (HCLK),
        .reset        (reset),
        .HTRANS       (HTRANS),
        .HSEL         (HSEL),
        .HSELOut      (HSELOut),
        .HRDATAS      (HRDATAS),
        .HREADYOUTS   (HREADYOUTS),
        .HRESPS       (HRESPS),
        .HRDATA       (HRDATA),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .Orphan       (Orphan),
        .TimeoutPulse (TimeoutPulse)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [63:0] bg(input int i);
        return {56'hA5A5_5A5A_0000_00, 8'(i)};
    endfunction

    function automatic vec_t mk(input string n, input logic [1:0] t, input logic [7:0] s,
                                input logic [7:0] so, input int slv, input int w,
                                input logic [63:0] d, input int k);
        vec_t v;
        v.name = n; v.htrans = t; v.hsel = s; v.hselout = so;
        v.slv = slv; v.waits = w; v.data = d; v.kind = k;
        return v;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Address phase followed by the whole data phase, checked cycle by cycle
    task automatic do_xfer(input vec_t v);
        HTRANS     = v.htrans;
        HSEL       = v.hsel;
        HREADYOUTS = idle_rdy;
        HRESPS     = '0;
        @(negedge HCLK);
        check64({v.name, ".hselout"}, 64'(HSELOut), 64'(v.hselout));
        check1({v.name, ".addr_hready"}, HREADY, 1'b1);
        step();
        HTRANS = IDLE;
        HSEL   = '0;
        case (v.kind)
            K_OK: begin
                for (int w = 0; w < v.waits; w++) begin
                    HREADYOUTS[v.slv] = 1'b0;
                    @(negedge HCLK);
                    check1({v.name, ".wait_hready"}, HREADY, 1'b0);
                    check1({v.name, ".wait_pulse"}, TimeoutPulse, 1'b0);
                    step();
                end
                HREADYOUTS[v.slv] = 1'b1;
                HRDATAS[v.slv*DW +: DW] = v.data;
                @(negedge HCLK);
                check1({v.name, ".done_hready"}, HREADY, 1'b1);
                check1({v.name, ".done_hresp"}, HRESP, 1'b0);
                check64({v.name, ".hrdata"}, HRDATA, v.data);
                check1({v.name, ".done_pulse"}, TimeoutPulse, 1'b0);
                step();
                HRDATAS[v.slv*DW +: DW] = bg(v.slv);
            end
            K_ERR: begin
                @(negedge HCLK);
                check1({v.name, ".err1_hready"}, HREADY, 1'b0);
                check1({v.name, ".err1_hresp"}, HRESP, 1'b1);
                check64({v.name, ".err_hrdata"}, HRDATA, 64'd0);
                step();
                @(negedge HCLK);
                check1({v.name, ".err2_hready"}, HREADY, 1'b1);
                check1({v.name, ".err2_hresp"}, HRESP, 1'b1);
                step();
            end
            K_IDLE: begin
                @(negedge HCLK);
                check1({v.name, ".idle_hready"}, HREADY, 1'b1);
                check1({v.name, ".idle_hresp"}, HRESP, 1'b0);
                check64({v.name, ".idle_hrdata"}, HRDATA, 64'd0);
                step();
            end
            default: begin
                HREADYOUTS[v.slv] = 1'b0;
                HRESPS[v.slv]     = 1'b1;
                @(negedge HCLK);
                check1({v.name, ".serr1_hready"}, HREADY, 1'b0);
                check1({v.name, ".serr1_hresp"}, HRESP, 1'b1);
                step();
                HREADYOUTS[v.slv] = 1'b1;
                @(negedge HCLK);
                check1({v.name, ".serr2_hready"}, HREADY, 1'b1);
                check1({v.name, ".serr2_hresp"}, HRESP, 1'b1);
                step();
                HRESPS = '0;
            end
        endcase
    endtask

    initial begin
        vecs[0] = mk("slv3_2ws",   NONSEQ, 8'h08, 8'h08, 3, 2, 64'hDEAD_BEEF_0123_4567, K_OK);
        vecs[1] = mk("unmapped",   NONSEQ, 8'h00, 8'h00, 0, 0, 64'd0, K_ERR);
        vecs[2] = mk("idle_none",  IDLE,   8'h00, 8'h00, 0, 0, 64'd0, K_IDLE);
        vecs[3] = mk("multi_hot",  NONSEQ, 8'h06, 8'h06, 0, 0, 64'd0, K_ERR);
        vecs[4] = mk("slv0_0ws",   SEQ,    8'h01, 8'h01, 0, 0, 64'h0123_4567_89AB_CDEF, K_OK);
        vecs[5] = mk("slv7_1ws",   NONSEQ, 8'h80, 8'h80, 7, 1, 64'hFEDC_BA98_7654_3210, K_OK);
        vecs[6] = mk("slv1_err",   NONSEQ, 8'h02, 8'h02, 1, 0, 64'd0, K_SERR);
        vecs[7] = mk("busy_none",  BUSY,   8'h00, 8'h00, 0, 0, 64'd0, K_IDLE);
        vecs[8] = mk("idle_multi", IDLE,   8'h06, 8'h06, 0, 0, 64'd0, K_IDLE);
        vecs[9] = mk("all_hot",    NONSEQ, 8'hFF, 8'hFF, 0, 0, 64'd0, K_ERR);

        for (int i = 0; i < NSLV; i++) HRDATAS[i*DW +: DW] = bg(i);
        idle_rdy   = '1;
        reset      = 1'b1;
        HTRANS     = IDLE;
        HSEL       = 8'hFF;
        HREADYOUTS = '1;
        HRESPS     = '0;

        // Reset state
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check1("rst.hready", HREADY, 1'b1);
        check1("rst.hresp", HRESP, 1'b0);
        check64("rst.hrdata", HRDATA, 64'd0);
        check1("rst.pulse", TimeoutPulse, 1'b0);
        check64("rst.orphan", 64'(Orphan), 64'd0);
        check64("rst.hselout", 64'(HSELOut), 64'hFF);
        HSEL = '0;
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 10; i++) do_xfer(vecs[i]);

        // Watchdog abort on slave 5
        HTRANS = NONSEQ; HSEL = 8'h20; HREADYOUTS = idle_rdy;
        @(negedge HCLK);
        check64("wd.hselout", 64'(HSELOut), 64'h20);
        step();
        HTRANS = IDLE; HSEL = '0; HREADYOUTS[5] = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge HCLK);
            check1("wd.stall_hready", HREADY, 1'b0);
            check1("wd.stall_pulse", TimeoutPulse, k == TIMEOUT);
            step();
        end
        @(negedge HCLK);
        check1("wd.err1_hready", HREADY, 1'b0);
        check1("wd.err1_hresp", HRESP, 1'b1);
        check1("wd.err1_pulse", TimeoutPulse, 1'b0);
        check64("wd.orphan", 64'(Orphan), 64'h20);
        step();
        @(negedge HCLK);
        check1("wd.err2_hready", HREADY, 1'b1);
        check1("wd.err2_hresp", HRESP, 1'b1);
        step();

        // Orphaned slave is fenced off; a second slave racing the limit completes
        idle_rdy = 8'hDF;
        do_xfer(mk("orphan_blocked", NONSEQ, 8'h20, 8'h00, 5, 0, 64'd0, K_ERR));
        check64("orphan.held", 64'(Orphan), 64'h20);
        do_xfer(mk("wd_race", NONSEQ, 8'h40, 8'h40, 6, TIMEOUT - 1, 64'hCAFE_F00D_5555_AAAA,
                   K_OK));
        check64("race.orphan", 64'(Orphan), 64'h20);

        // Late response releases slave 5
        idle_rdy = '1; HREADYOUTS = '1;
        @(negedge HCLK);
        check64("recover.same_cycle", 64'(Orphan), 64'h20);
        step();
        @(negedge HCLK);
        check64("recover.cleared", 64'(Orphan), 64'h00);
        step();
        do_xfer(mk("slv5_after", NONSEQ, 8'h20, 8'h20, 5, 1, 64'h1357_9BDF_2468_ACE0, K_OK));

        // Reset while slave 2 is stalled with Count=7
        HTRANS = NONSEQ; HSEL = 8'h04; HREADYOUTS = idle_rdy;
        step();
        HTRANS = IDLE; HSEL = '0; HREADYOUTS[2] = 1'b0;
        repeat (7) step();
        check1("mid.stalled", HREADY, 1'b0);
        #1 reset = 1'b1;
        #1;
        check1("mid.rst_hready", HREADY, 1'b1);
        check1("mid.rst_hresp", HRESP, 1'b0);
        check64("mid.rst_hrdata", HRDATA, 64'd0);
        check1("mid.rst_pulse", TimeoutPulse, 1'b0);
        step();
        reset = 1'b0;
        repeat (TIMEOUT + 4) step();
        @(negedge HCLK);
        check64("mid.no_orphan", 64'(Orphan), 64'd0);
        check1("mid.idle_hready", HREADY, 1'b1);
        step();
        do_xfer(mk("slv2_post_rst", NONSEQ, 8'h04, 8'h04, 2, TIMEOUT - 1, 64'h0F0F_1E1E_2D2D_3C3C,
                   K_OK));
        check64("post_rst.orphan", 64'(Orphan), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
